// File: rtl/sparc_ifu_thrsched_pkg.sv
// rtl/sparc_ifu_thrsched_pkg.sv - shared constants and state encoding for the IFU thread scheduler
package sparc_ifu_thrsched_pkg;

    localparam int NTHR = 4;

    typedef enum logic [1:0] {
        TS_IDLE   = 2'd0,
        TS_RUN    = 2'd1,
        TS_SWITCH = 2'd2
    } ts_state_t;

    localparam logic [NTHR-1:0] THR0 = 4'b0001;
    localparam logic [NTHR-1:0] THR1 = 4'b0010;
    localparam logic [NTHR-1:0] THR2 = 4'b0100;
    localparam logic [NTHR-1:0] THR3 = 4'b1000;

    // Entry 0 is the oldest (least recently scheduled) thread.
    localparam logic [NTHR-1:0][1:0] LRU_RESET = {2'd3, 2'd2, 2'd1, 2'd0};

endpackage

// File: rtl/sparc_ifu_thrsched_lru.sv
// rtl/sparc_ifu_thrsched_lru.sv - LRU list: combinational oldest-candidate pick, registered move-to-MRU update
module sparc_ifu_thrsched_lru
    import sparc_ifu_thrsched_pkg::*;
(
    input  logic            clk,
    input  logic            arst_l,
    input  logic [NTHR-1:0] cand,
    input  logic            upd,
    output logic [NTHR-1:0] win
);

    logic [NTHR-1:0][1:0] lru_q;
    logic [NTHR-1:0][1:0] lru_d;
    logic [1:0]           hit;
    logic                 any;

    always_comb begin
        hit   = 2'd0;
        any   = 1'b0;
        lru_d = lru_q;
        // Descending scan so the oldest matching entry is the one that sticks.
        for (int i = NTHR - 1; i >= 0; i--) begin
            if (cand[lru_q[i]]) begin
                hit = 2'(i);
                any = 1'b1;
            end
        end
        win = any ? (4'b0001 << lru_q[hit]) : 4'b0000;
        for (int i = 0; i < NTHR - 1; i++) begin
            lru_d[i] = (2'(i) < hit) ? lru_q[i] : lru_q[i+1];
        end
        lru_d[NTHR-1] = lru_q[hit];
    end

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            lru_q <= LRU_RESET;
        end else if (upd && any) begin
            lru_q <= lru_d;
        end
    end

endmodule

// File: rtl/sparc_ifu_thrsched.sv
// rtl/sparc_ifu_thrsched.sv - per-core thread scheduler top; run quantum enabled by IFU_THRSCHED_QUANTUM_EN
module sparc_ifu_thrsched
    import sparc_ifu_thrsched_pkg::*;
#(
    parameter int QW = 4
) (
    input  logic            clk,
    input  logic            arst_l,
    input  logic [NTHR-1:0] thr_rdy,
    input  logic [NTHR-1:0] thr_spec_rdy,
    input  logic [NTHR-1:0] thr_run,
    input  logic            fcl_stall,
    input  logic            sw_req,
    input  logic [QW-1:0]   quantum,
    output logic [NTHR-1:0] schedule,
    output logic            switch_out,
    output logic [NTHR-1:0] cur_thr,
    output logic            sched_spec
);

    ts_state_t       state_q, state_d;
    logic [NTHR-1:0] cand;
    logic [NTHR-1:0] win;
    logic [NTHR-1:0] sched_d, cur_d;
    logic            sw_d, spec_d, pick;
    logic            q_expire;

    // Speculative threads are only considered when nothing is plainly ready.
    assign cand = (|thr_rdy) ? thr_rdy : thr_spec_rdy;

    sparc_ifu_thrsched_lru u_lru (
        .clk    (clk),
        .arst_l (arst_l),
        .cand   (cand),
        .upd    (pick),
        .win    (win)
    );

`ifdef IFU_THRSCHED_QUANTUM_EN
    logic [QW-1:0] qcnt_q, qcnt_d;

    // Slice expiry yields only when someone else is waiting; a lone thread parks at 1.
    assign q_expire = (qcnt_q == QW'(1)) && (quantum != '0) && (|(cand & ~cur_thr));

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            qcnt_q <= '0;
        end else begin
            qcnt_q <= qcnt_d;
        end
    end
`else
    logic quantum_unused;
    assign quantum_unused = ^quantum;
    assign q_expire       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cur_d   = cur_thr;
        sched_d = '0;
        sw_d    = 1'b0;
        spec_d  = 1'b0;
        pick    = 1'b0;
`ifdef IFU_THRSCHED_QUANTUM_EN
        qcnt_d  = qcnt_q;
`endif
        unique case (state_q)
            TS_IDLE: begin
                if (!fcl_stall && (|cand)) begin
                    pick    = 1'b1;
                    sched_d = win;
                    cur_d   = win;
                    spec_d  = ~(|thr_rdy);
                    state_d = TS_RUN;
`ifdef IFU_THRSCHED_QUANTUM_EN
                    qcnt_d  = quantum;
`endif
                end
            end
            TS_RUN: begin
                if (~(|(cur_thr & thr_run))) begin
                    cur_d   = '0;
                    state_d = TS_IDLE;
                end else if (!fcl_stall) begin
                    if (sw_req || q_expire) begin
                        sw_d    = 1'b1;
                        state_d = TS_SWITCH;
                    end
`ifdef IFU_THRSCHED_QUANTUM_EN
                    else if (qcnt_q > QW'(1)) begin
                        qcnt_d = qcnt_q - QW'(1);
                    end
`endif
                end
            end
            TS_SWITCH: begin
                cur_d   = '0;
                state_d = TS_IDLE;
            end
            default: begin
                cur_d   = '0;
                state_d = TS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            state_q    <= TS_IDLE;
            schedule   <= '0;
            switch_out <= 1'b0;
            cur_thr    <= '0;
            sched_spec <= 1'b0;
        end else begin
            state_q    <= state_d;
            schedule   <= sched_d;
            switch_out <= sw_d;
            cur_thr    <= cur_d;
            sched_spec <= spec_d;
        end
    end

endmodule

// File: tb/tb_sparc_ifu_thrsched.sv
// tb/tb_sparc_ifu_thrsched.sv - self-checking bench: vector table, corner sequences, randomized model compare
module tb_sparc_ifu_thrsched;

`ifdef IFU_THRSCHED_QUANTUM_EN
    localparam bit QEN = 1'b1;
`else
    localparam bit QEN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       arst_l = 1'b0;
    logic [3:0] thr_rdy = '0, thr_spec_rdy = '0, thr_run = '0;
    logic       fcl_stall = 1'b0, sw_req = 1'b0;
    logic [3:0] quantum = '0;
    logic [3:0] schedule, cur_thr;
    logic       switch_out, sched_spec;

    int tests = 0;
    int fails = 0;

    sparc_ifu_thrsched #(.QW(4)) dut (
        .clk          (clk),
        .arst_l       (arst_l),
        .thr_rdy      (thr_rdy),
        .thr_spec_rdy (thr_spec_rdy),
        .thr_run      (thr_run),
        .fcl_stall    (fcl_stall),
        .sw_req       (sw_req),
        .quantum      (quantum),
        .schedule     (schedule),
        .switch_out   (switch_out),
        .cur_thr      (cur_thr),
        .sched_spec   (sched_spec)
    );

    always #5 clk = ~clk;

    // Reference model: LRU as a queue of thread ids, oldest at the front.
    int         lru_m[$];
    int         run_id;
    bit         in_sw;
    int         slice;
    logic [3:0] m_sched, m_cur;
    logic       m_sw, m_spec;

    task automatic model_reset();
        lru_m   = '{0, 1, 2, 3};
        run_id  = -1;
        in_sw   = 1'b0;
        slice   = 0;
        m_sched = '0;
        m_cur   = '0;
        m_sw    = 1'b0;
        m_spec  = 1'b0;
    endtask

    task automatic model_step();
        logic [3:0] cand;
        int k;
        cand    = (thr_rdy != 0) ? thr_rdy : thr_spec_rdy;
        m_sched = '0;
        m_sw    = 1'b0;
        m_spec  = 1'b0;
        if (in_sw) begin
            in_sw  = 1'b0;
            run_id = -1;
        end else if (run_id < 0) begin
            if (!fcl_stall && cand != 0) begin
                k = 0;
                while (!cand[lru_m[k]]) k++;
                run_id = lru_m[k];
                lru_m.delete(k);
                lru_m.push_back(run_id);
                m_sched = 4'b0001 << run_id;
                m_spec  = (thr_rdy == 0);
                slice   = int'(quantum);
            end
        end else if (!thr_run[run_id]) begin
            run_id = -1;
        end else if (!fcl_stall) begin
            if (sw_req || (QEN && slice == 1 && quantum != 0 && (cand & ~(4'b0001 << run_id)) != 0)) begin
                m_sw  = 1'b1;
                in_sw = 1'b1;
            end else if (slice > 1) begin
                slice--;
            end
        end
        m_cur = (run_id < 0) ? 4'b0000 : (4'b0001 << run_id);
    endtask

    task automatic chk_out(input string name, input logic [3:0] es, input logic ew,
                           input logic [3:0] ec, input logic ep);
        tests++;
        if ({schedule, switch_out, cur_thr, sched_spec} !== {es, ew, ec, ep}) begin
            fails++;
            $display("FAIL %s: got sched=%b sw=%b cur=%b spec=%b, expected sched=%b sw=%b cur=%b spec=%b",
                     name, schedule, switch_out, cur_thr, sched_spec, es, ew, ec, ep);
        end
    endtask

    task automatic set_in(input logic [3:0] r, input logic [3:0] s, input logic [3:0] ru,
                          input logic st, input logic sw, input logic [3:0] q);
        thr_rdy = r; thr_spec_rdy = s; thr_run = ru;
        fcl_stall = st; sw_req = sw; quantum = q;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string name);
        #2 arst_l = 1'b0;
        set_in(4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 4'd0);
        model_reset();
        #1 chk_out(name, 4'b0, 1'b0, 4'b0, 1'b0);
        @(posedge clk);
        #1 arst_l = 1'b1;
    endtask

    typedef struct {
        logic [3:0] rdy, spec, run;
        logic       stall, swr;
        logic [3:0] e_sched;
        logic       e_sw;
        logic [3:0] e_cur;
        logic       e_spec;
    } vec_t;

    vec_t vecs[$];
    logic hold_sw;

    initial begin
        model_reset();
        do_reset("reset_initial");

        // rdy spec run stall swr | sched sw cur spec   (quantum held at 0)
        vecs.push_back('{4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 0});
        vecs.push_back('{4'b1010, 4'b0000, 4'b0000, 0, 0, 4'b0010, 0, 4'b0010, 0});
        vecs.push_back('{4'b0000, 4'b0000, 4'b0010, 0, 0, 4'b0000, 0, 4'b0010, 0});
        vecs.push_back('{4'b1000, 4'b0000, 4'b0010, 0, 1, 4'b0000, 1, 4'b0010, 0});
        vecs.push_back('{4'b1000, 4'b0000, 4'b0010, 0, 0, 4'b0000, 0, 4'b0000, 0});
        vecs.push_back('{4'b1000, 4'b0100, 4'b0000, 0, 0, 4'b1000, 0, 4'b1000, 0});
        vecs.push_back('{4'b0000, 4'b0100, 4'b1000, 0, 0, 4'b0000, 0, 4'b1000, 0});
        vecs.push_back('{4'b0000, 4'b0100, 4'b0000, 0, 1, 4'b0000, 0, 4'b0000, 0});
        vecs.push_back('{4'b0000, 4'b0110, 4'b0000, 0, 0, 4'b0100, 0, 4'b0100, 1});
        vecs.push_back('{4'b0000, 4'b0000, 4'b0100, 1, 1, 4'b0000, 0, 4'b0100, 0});
        vecs.push_back('{4'b0000, 4'b0000, 4'b0100, 0, 1, 4'b0000, 1, 4'b0100, 0});
        vecs.push_back('{4'b0000, 4'b0000, 4'b0100, 0, 0, 4'b0000, 0, 4'b0000, 0});
        vecs.push_back('{4'b1111, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 4'b0000, 0});
        vecs.push_back('{4'b1111, 4'b0000, 4'b0000, 0, 0, 4'b0001, 0, 4'b0001, 0});
        vecs.push_back('{4'b0000, 4'b0100, 4'b0001, 0, 0, 4'b0000, 0, 4'b0001, 0});
        vecs.push_back('{4'b0000, 4'b0100, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 0});
        vecs.push_back('{4'b0001, 4'b0100, 4'b0000, 0, 0, 4'b0001, 0, 4'b0001, 0});
        vecs.push_back('{4'b1111, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 0});
        vecs.push_back('{4'b1111, 4'b0000, 4'b0000, 0, 0, 4'b0010, 0, 4'b0010, 0});
        vecs.push_back('{4'b1111, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 4'b0000, 0});
        vecs.push_back('{4'b1111, 4'b0000, 4'b0000, 0, 0, 4'b1000, 0, 4'b1000, 0});

        for (int i = 0; i < vecs.size(); i++) begin
            set_in(vecs[i].rdy, vecs[i].spec, vecs[i].run, vecs[i].stall, vecs[i].swr, 4'd0);
            step();
            chk_out($sformatf("vec%0d", i), vecs[i].e_sched, vecs[i].e_sw, vecs[i].e_cur, vecs[i].e_spec);
        end

        // Quantum slice: T1 runs with T3 waiting.
        do_reset("reset_quantum");
`ifdef IFU_THRSCHED_QUANTUM_EN
        set_in(4'b0010, 4'b0, 4'b0, 0, 0, 4'd3); step();
        chk_out("q_sched_t1", 4'b0010, 0, 4'b0010, 0);
        set_in(4'b1000, 4'b0, 4'b0010, 0, 0, 4'd3);
        step(); chk_out("q_run1", 4'b0, 0, 4'b0010, 0);
        step(); chk_out("q_run2", 4'b0, 0, 4'b0010, 0);
        step(); chk_out("q_expire", 4'b0, 1, 4'b0010, 0);
        step(); chk_out("q_bubble", 4'b0, 0, 4'b0, 0);
        set_in(4'b1000, 4'b0, 4'b0, 0, 0, 4'd3); step();
        chk_out("q_sched_t3", 4'b1000, 0, 4'b1000, 0);
        set_in(4'b0, 4'b0, 4'b0, 0, 0, 4'd0); step();
        chk_out("q_t3_done", 4'b0, 0, 4'b0, 0);
        set_in(4'b1010, 4'b0, 4'b0, 0, 0, 4'd0); step();
        chk_out("q_lru_t1_older", 4'b0010, 0, 4'b0010, 0);
`else
        set_in(4'b0010, 4'b0, 4'b0, 0, 0, 4'd1); step();
        chk_out("q_sched_t1", 4'b0010, 0, 4'b0010, 0);
        set_in(4'b1000, 4'b0, 4'b0010, 0, 0, 4'd1);
        for (int i = 0; i < 8; i++) begin
            step(); chk_out($sformatf("q_noswitch%0d", i), 4'b0, 0, 4'b0010, 0);
        end
        set_in(4'b1000, 4'b0, 4'b0010, 0, 1, 4'd1); step();
        chk_out("q_swreq", 4'b0, 1, 4'b0010, 0);
`endif

        // Stall freezes the slice counter and the strobes.
        do_reset("reset_stall");
        hold_sw = ~QEN;
        set_in(4'b0001, 4'b0, 4'b0, 0, 0, 4'd2); step();
        chk_out("st_sched_t0", 4'b0001, 0, 4'b0001, 0);
        set_in(4'b0100, 4'b0, 4'b0001, 0, 0, 4'd2); step();
        chk_out("st_run1", 4'b0, 0, 4'b0001, 0);
        set_in(4'b0100, 4'b0, 4'b0001, 1, hold_sw, 4'd2);
        for (int i = 0; i < 5; i++) begin
            step(); chk_out($sformatf("st_frozen%0d", i), 4'b0, 0, 4'b0001, 0);
        end
        set_in(4'b0100, 4'b0, 4'b0001, 0, hold_sw, 4'd2); step();
        chk_out("st_release", 4'b0, 1, 4'b0001, 0);

        // Reset during the switch bubble restores the LRU order.
        do_reset("reset_pre_sw");
        set_in(4'b0100, 4'b0, 4'b0, 0, 0, 4'd0); step();
        chk_out("rs_sched_t2", 4'b0100, 0, 4'b0100, 0);
        set_in(4'b0000, 4'b0, 4'b0100, 0, 1, 4'd0); step();
        chk_out("rs_switch", 4'b0, 1, 4'b0100, 0);
        do_reset("reset_mid_switch");
        set_in(4'b0000, 4'b0, 4'b0, 0, 0, 4'd0); step();
        chk_out("rs_no_strobe", 4'b0, 0, 4'b0, 0);
        set_in(4'b1111, 4'b0, 4'b0, 0, 0, 4'd0); step();
        chk_out("rs_lru_reset", 4'b0001, 0, 4'b0001, 0);

        // Randomized run against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset("reset_rand");
            end
            thr_rdy      = ($urandom_range(0, 2) == 0) ? 4'b0 : 4'($urandom);
            thr_spec_rdy = 4'($urandom);
            thr_run      = (run_id >= 0 && $urandom_range(0, 15) != 0) ? (4'b0001 << run_id) : 4'b0;
            fcl_stall    = ($urandom_range(0, 4) == 0);
            sw_req       = ($urandom_range(0, 7) == 0);
            quantum      = 4'($urandom_range(0, 4));
            step();
            chk_out($sformatf("rand%0d", n), m_sched, m_sw, m_cur, m_spec);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
